// File: rtl/tpu_pkg.sv
// Shared constants and FSM encoding for the TPU result read-out path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tpu_pkg;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int SRAM_RD_LAT    = 1;
  localparam int FIFO_DEPTH     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry synchronous FIFO buffering SRAM read data toward the host.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: the caller guarantees no push when full and no pop when empty.
module result_fifo2
  import tpu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic [1:0]   count
);

  logic [W-1:0] mem [FIFO_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;

  // Storage, pointers and occupancy; push and pop together keep count and order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/result_reader.sv
// Streams num_words consecutive SRAM words from base_addr to the host.
// Latency: start at edge E0 -> sram_rd_req in cycle 1, first dout_valid in cycle 3.
// Backpressure: dout_ready low holds dout; reads stop once buffered plus in-flight reaches 2.
module result_reader
  import tpu_pkg::*;
#(
  parameter int datawith   = 16,
  parameter int array_size = 2,
  parameter int ADDR_W     = DEFAULT_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     num_words,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic                sram_rd_req,
  input  logic [datawith-1:0] sram_rdata,
  output logic [datawith-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                dout_last,
  output logic                busy,
  output logic                done
);

  // A full array result must fit in the address space, and the credit scheme
  // below relies on a one-cycle SRAM read and exactly two buffer entries.
  if (array_size * array_size > (1 << ADDR_W) || SRAM_RD_LAT != 1 || FIFO_DEPTH != 2)
  begin : g_bad_cfg
    $error("result_reader: unsupported configuration");
  end

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  rd_state_t         state_q;
  rd_state_t         state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   issued_q;
  logic [ADDR_W:0]   remaining_q;
  logic [ADDR_W:0]   num_q;
  logic              inflight_q;
  logic [1:0]        fifo_count;
  logic [2:0]        occupancy;
  logic              pop;
  logic              issue;
  logic              accept;

  assign pop    = dout_valid & dout_ready;
  assign accept = (state_q == ST_IDLE) && start && (num_words != '0);

  // Words already owed to the host: buffered plus the one still in the SRAM.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus issue/busy/done decode.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (num_words == '0) ? ST_DONE : ST_READ;
      end
      ST_READ: begin
        busy = 1'b1;
        if (occupancy < 3'd2) begin
          issue = 1'b1;
          if (issued_q + CNT_ONE == num_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (pop && remaining_q == CNT_ONE) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transfer bookkeeping: latch the request, advance the address, count pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      issued_q    <= '0;
      remaining_q <= '0;
      num_q       <= '0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (accept) begin
        addr_q      <= base_addr;
        issued_q    <= '0;
        remaining_q <= num_words;
        num_q       <= num_words;
      end else begin
        if (issue) begin
          addr_q   <= addr_q + 1'b1;
          issued_q <= issued_q + CNT_ONE;
        end
        if (pop) remaining_q <= remaining_q - CNT_ONE;
      end
    end
  end

  // Read data arrives the cycle after the address; the credit check keeps it from overflowing.
  result_fifo2 #(
    .W (datawith)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight_q),
    .push_dat (sram_rdata),
    .pop      (pop),
    .head_dat (dout),
    .count    (fifo_count)
  );

  assign sram_rd_req = issue;
  assign sram_addr   = issue ? addr_q : '0;
  assign dout_valid  = (fifo_count != 2'd0);
  assign dout_last   = dout_valid && (remaining_q == CNT_ONE);

endmodule

// File: tb/tb_result_reader.sv
module tb_result_reader;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int MEM_WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic [AW-1:0] sram_addr;
  logic          sram_rd_req;
  logic [DW-1:0] sram_rdata = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic          dout_last;
  logic          busy;
  logic          done;

  result_reader #(.datawith(DW), .array_size(2), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .sram_addr(sram_addr), .sram_rd_req(sram_rd_req),
    .sram_rdata(sram_rdata), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM with one-cycle registered read.
  logic [DW-1:0] mem [MEM_WORDS];
  always @(posedge clk) sram_rdata <= mem[sram_addr];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard state: expected words, last flags and addresses per transfer.
  int  exp_dat[$];
  bit  exp_last[$];
  int  exp_addr[$];
  int  req_addrs[$];
  bit  xfer_open = 1'b0;
  int  exp_done = 0;
  int  got_done = 0;
  int  n_iss = 0;
  int  n_pop = 0;
  int  cyc = 0;
  int  c0 = 0;
  int  first_req_rel = -1;
  int  first_val_rel = -1;
  int  done_rel = -1;
  int  busy_cnt = 0;
  int  rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Host ready: always 1, a fixed toggle pattern after start, or random.
  initial begin
    int pat [7];
    int idx;
    pat = '{1, 0, 0, 1, 0, 1, 1};
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin
          idx = cyc - c0;
          dout_ready = (idx >= 0 && idx < 7) ? pat[idx][0] : 1'b1;
        end
        2: dout_ready = 1'($urandom_range(0, 1));
        default: dout_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every address issue and every host handshake against the model.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_dout = '0;
  always @(negedge clk) begin
    int rel;
    bit pop_now;
    rel = cyc - c0 + 1;
    pop_now = dout_valid && dout_ready;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (sram_rd_req) begin
        if (first_req_rel < 0) first_req_rel = rel;
        req_addrs.push_back(int'(sram_addr));
        chk("req_expected", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) chk("sram_addr", sram_addr, exp_addr.pop_front());
        chk("outstanding_le2", (n_iss - n_pop - int'(pop_now) + 1) <= 2, 1);
        n_iss++;
      end
      if (prev_stall) begin
        chk("stall_valid", dout_valid, 1);
        chk("stall_dout", dout, prev_dout);
      end
      if (dout_valid && first_val_rel < 0) first_val_rel = rel;
      if (pop_now) begin
        chk("pop_expected", exp_dat.size() > 0, 1);
        if (exp_dat.size() > 0) begin
          chk("dout", dout, exp_dat.pop_front());
          chk("dout_last", dout_last, exp_last.pop_front());
        end
        n_pop++;
      end
      if (busy) busy_cnt++;
      if (done) begin
        got_done++;
        done_rel = rel;
        chk("done_drained", exp_dat.size(), 0);
        chk("done_busy_low", busy, 0);
        xfer_open = 1'b0;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
    end
  end

  task automatic do_start(input int base, input int n);
    bit acc;
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = AW'(base);
    num_words = (AW + 1)'(n);
    acc = !xfer_open;
    if (acc) begin
      xfer_open = 1'b1;
      exp_done++;
      n_iss = 0;
      n_pop = 0;
      first_req_rel = -1;
      first_val_rel = -1;
      done_rel = -1;
      busy_cnt = 0;
      req_addrs.delete();
      for (int i = 0; i < n; i++) begin
        exp_dat.push_back(int'(mem[(base + i) % MEM_WORDS]));
        exp_last.push_back(i == n - 1);
        exp_addr.push_back((base + i) % MEM_WORDS);
      end
    end
    @(posedge clk);
    #1;
    if (acc) c0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && xfer_open; i++) @(negedge clk);
    chk("xfer_timeout", xfer_open, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_dout_valid"}, dout_valid, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_dout_last"}, dout_last, 0);
    chk({tag, "_sram_rd_req"}, sram_rd_req, 0);
    chk({tag, "_sram_addr"}, sram_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int done_before;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = DW'($urandom);
    mem[16] = 16'h1111; mem[17] = 16'h2222; mem[18] = 16'h3333; mem[19] = 16'h4444;
    mem[32] = 16'hA5A5; mem[33] = 16'h5A5A;

    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // Basic 4-word read with ready held high: cycle-accurate timing.
    do_start(16, 4);
    wait_idle(200);
    chk("basic_first_req", first_req_rel, 1);
    chk("basic_first_valid", first_val_rel, 3);
    chk("basic_done_cycle", done_rel, 7);
    chk("basic_busy_cycles", busy_cnt, 6);
    chk("basic_words", n_pop, 4);

    // Backpressure with the toggle pattern.
    rdy_mode = 1;
    do_start(16, 4);
    wait_idle(200);
    rdy_mode = 0;
    chk("bp_words", n_pop, 4);

    // Zero-length request.
    do_start(5, 0);
    wait_idle(50);
    chk("zero_no_req", first_req_rel, -1);
    chk("zero_no_valid", first_val_rel, -1);
    chk("zero_done_cycle", done_rel, 1);

    // Address wrap.
    do_start(1022, 4);
    wait_idle(200);
    chk("wrap_req_count", req_addrs.size(), 4);
    if (req_addrs.size() == 4) begin
      chk("wrap_addr0", req_addrs[0], 1022);
      chk("wrap_addr1", req_addrs[1], 1023);
      chk("wrap_addr2", req_addrs[2], 0);
      chk("wrap_addr3", req_addrs[3], 1);
    end

    // Start while busy is ignored.
    done_before = got_done;
    do_start(16, 4);
    do_start(256, 4);
    wait_idle(200);
    repeat (10) @(negedge clk);
    chk("busy_start_one_done", got_done - done_before, 1);
    chk("busy_start_words", n_pop, 4);
    chk("busy_start_no_extra_req", n_iss, 4);

    // Reset after two accepted words, then a fresh transfer.
    do_start(16, 4);
    for (int i = 0; i < 200 && n_pop < 2; i++) @(negedge clk);
    chk("mid_reset_reached", n_pop, 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    exp_dat.delete();
    exp_last.delete();
    exp_addr.delete();
    xfer_open = 1'b0;
    exp_done--;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    do_start(32, 2);
    wait_idle(200);
    chk("post_reset_words", n_pop, 2);

    // Maximum length at full rate.
    do_start(7, MEM_WORDS);
    wait_idle(5000);
    chk("max_len_words", n_pop, MEM_WORDS);

    // Randomised transfers with random host backpressure.
    rdy_mode = 2;
    for (int k = 0; k < 20; k++) begin
      int b;
      int n;
      b = $urandom_range(0, MEM_WORDS - 1);
      n = (k % 6 == 0) ? 0 : $urandom_range(1, 12);
      do_start(b, n);
      wait_idle(1000);
      chk("rand_words", n_pop, n);
    end
    rdy_mode = 0;

    repeat (5) @(negedge clk);
    chk("final_queue_empty", exp_dat.size(), 0);
    chk("final_done_count", got_done, exp_done);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
